// File: rtl/div_pkg.sv
// Shared definitions for the shared iterative divider and its arbiter.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    FIX  = 2'd2,
    RESP = 2'd3
  } div_state_e;

  localparam int DIV_W    = 4;
  localparam int DIV_NREQ = 4;

  // Quotient reported on divide-by-zero: all ones, truncated by the caller.
  function automatic logic [63:0] dbz_quotient();
    return '1;
  endfunction

endpackage

// File: rtl/div_share_arbiter_rr_arbiter.sv
// Round-robin arbiter: searches from ptr upward with wrap and grants the
// first active request. Produces a one-hot grant and its encoded index.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  input  logic            en,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  gnt_idx
);

  // Priority search starting at ptr, wrapping at NREQ.
  always_comb begin
    logic           found;
    int             j;
    logic [IDW-1:0] jj;
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    j       = 0;
    jj      = '0;
    for (int k = 0; k < NREQ; k++) begin
      j = int'(ptr) + k;
      if (j >= NREQ) j = j - NREQ;
      jj = IDW'(j);
      if (en && !found && req[jj]) begin
        found   = 1'b1;
        gnt[jj] = 1'b1;
        gnt_idx = jj;
      end
    end
  end

endmodule

// File: rtl/div_share_arbiter.sv
// Shares one non-restoring divide engine among NREQ requesters.
// Optional build macro: DIV_TRIVIAL_BYPASS_EN answers X<Y and Y==1 in a
// single cycle instead of running the iterative engine.
module div_share_arbiter
  import div_pkg::*;
#(
  parameter int NREQ = DIV_NREQ,
  parameter int W    = DIV_W,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*W-1:0] req_x,
  input  logic [NREQ*W-1:0] req_y,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [IDW-1:0]  rsp_id,
  output logic [W-1:0]    rsp_q,
  output logic [W:0]      rsp_r,
  output logic            rsp_dbz,
  output logic            busy
);

  localparam int CW = $clog2(W + 1);

  div_state_e        state;
  logic [IDW-1:0]    ptr;
  logic [CW-1:0]     cnt;
  logic signed [W:0] a;
  logic [W-1:0]      q;
  logic [W-1:0]      m;

  logic [NREQ-1:0]   gnt;
  logic [IDW-1:0]    gnt_idx;
  logic              arb_en;
  logic              take;
  logic [W-1:0]      sel_x;
  logic [W-1:0]      sel_y;
  logic [IDW-1:0]    ptr_next;

  logic signed [W:0] m_ext;
  logic signed [W:0] a_sh;
  logic signed [W:0] a_step;
  logic signed [W:0] a_fix;
  logic [W-1:0]      q_step;

  // Grants are only offered while idle and out of reset, so req_ready is
  // all-zero during reset even with requesters asserting valid.
  assign arb_en = (state == IDLE) && rst_n;

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .req     (req_valid),
    .ptr     (ptr),
    .en      (arb_en),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign req_ready = gnt;
  assign take      = |gnt;
  assign ptr_next  = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
  assign rsp_valid = (state == RESP);
  assign busy      = (state != IDLE);

  // Operand mux driven by the one-hot grant.
  always_comb begin
    sel_x = '0;
    sel_y = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        sel_x = sel_x | req_x[i*W +: W];
        sel_y = sel_y | req_y[i*W +: W];
      end
    end
  end

  // One non-restoring step plus the final remainder correction.
  always_comb begin
    m_ext  = signed'({1'b0, m});
    a_sh   = {a[W-1:0], q[W-1]};
    a_step = a[W] ? (a_sh + m_ext) : (a_sh - m_ext);
    q_step = {q[W-2:0], ~a_step[W]};
    a_fix  = a[W] ? (a + m_ext) : a;
  end

  // Control FSM and registered response fields.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      ptr     <= '0;
      cnt     <= '0;
      rsp_id  <= '0;
      rsp_q   <= '0;
      rsp_r   <= '0;
      rsp_dbz <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (take) begin
            rsp_id <= gnt_idx;
            ptr    <= ptr_next;
            cnt    <= CW'(W);
            if (sel_y == '0) begin
              rsp_q   <= W'(dbz_quotient());
              rsp_r   <= {1'b0, sel_x};
              rsp_dbz <= 1'b1;
              state   <= RESP;
            end
`ifdef DIV_TRIVIAL_BYPASS_EN
            else if (sel_x < sel_y) begin
              rsp_q   <= '0;
              rsp_r   <= {1'b0, sel_x};
              rsp_dbz <= 1'b0;
              state   <= RESP;
            end else if (sel_y == W'(1)) begin
              rsp_q   <= sel_x;
              rsp_r   <= '0;
              rsp_dbz <= 1'b0;
              state   <= RESP;
            end
`endif
            else begin
              rsp_dbz <= 1'b0;
              state   <= ITER;
            end
          end
        end
        ITER: begin
          cnt <= cnt - 1'b1;
          if (cnt == CW'(1)) state <= FIX;
        end
        FIX: begin
          rsp_q <= q;
          rsp_r <= a_fix;
          state <= RESP;
        end
        RESP: begin
          if (rsp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Divide datapath registers; loaded at the grant, stepped while iterating.
  always_ff @(posedge clk) begin
    if (state == IDLE && take) begin
      a <= '0;
      q <= sel_x;
      m <= sel_y;
    end else if (state == ITER) begin
      a <= a_step;
      q <= q_step;
    end
  end

endmodule
